// File: rtl/i2c_reg_init_seq_pkg.sv
// Shared types and constants for the I2C register-initialisation sequencer.
package i2c_cfg_pkg;

    // Sequencer states, one table entry is walked FETCH -> LOAD -> (DELAY | ISSUE/WAIT) -> NEXT.
    typedef enum logic [2:0] {
        FETCH = 3'd0,
        LOAD  = 3'd1,
        DELAY = 3'd2,
        ISSUE = 3'd3,
        WAIT  = 3'd4,
        NEXT  = 3'd5,
        DONE  = 3'd6
    } seq_state_t;

    // Sub-address value that turns a table entry into a wait instead of a write.
    localparam logic [7:0] DEFAULT_DELAY_CODE = 8'hFF;
    localparam logic [7:0] DEFAULT_SLAVE_ADDR = 8'h72;

    // System-clock cycles per controller work-clock tick; never below one.
    function automatic int tick_div(input int clk_freq, input int i2c_freq);
        int d;
        d = clk_freq / (2 * i2c_freq);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/i2c_reg_init_seq_if.sv
// ROM table port plus GO/END/ACK handshake towards the shared I2C byte controller.
interface i2c_reg_init_seq_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] oROM_ADDR;
    logic [15:0]       iROM_DATA;
    logic              oTICK;
    logic [23:0]       oI2C_DATA;
    logic              oI2C_GO;
    logic              iI2C_END;
    logic              iI2C_ACK;

    // Sequencer side.
    modport master (
        output oROM_ADDR, oTICK, oI2C_DATA, oI2C_GO,
        input  iROM_DATA, iI2C_END, iI2C_ACK
    );

    // ROM and controller side.
    modport slave (
        input  oROM_ADDR, oTICK, oI2C_DATA, oI2C_GO,
        output iROM_DATA, iI2C_END, iI2C_ACK
    );
endinterface

// File: rtl/i2c_reg_init_seq_tick_gen.sv
// Free-running divider giving a one-cycle enable per controller work-clock period.
module i2c_tick_gen
    import i2c_cfg_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int I2C_FREQ = 20000
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);
    localparam int DIV = tick_div(CLK_FREQ, I2C_FREQ);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_LAST);

    // Count 0..DIV-1 and wrap.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (w_wrap)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    // Masked by reset so a divide-by-one build still reads 0 while held in reset.
    assign o_tick = w_wrap & ~i_rst;

endmodule

// File: rtl/i2c_reg_init_seq.sv
// Table-driven I2C register-initialisation sequencer with NACK retry, delay entries
// and debounced-interrupt / start-pulse re-run.
//
// state | meaning
// FETCH | present current index on the ROM address
// LOAD  | ROM word valid: decode delay entry or latch the 3-byte write
// DELAY | count down delay ticks
// ISSUE | raise GO on the next tick
// WAIT  | wait for END on a tick; ACK -> NEXT, NACK -> retry or skip
// NEXT  | advance index or finish
// DONE  | sequence complete; watch iSTART and debounced interrupt
module i2c_reg_init_seq
    import i2c_cfg_pkg::*;
#(
    parameter int         CLK_FREQ    = 50000000,
    parameter int         I2C_FREQ    = 20000,
    parameter logic [7:0] SLAVE_ADDR  = DEFAULT_SLAVE_ADDR,
    parameter int         ENTRIES     = 31,
    parameter int         ADDR_W      = 6,
    parameter int         MAX_RETRY   = 3,
    parameter logic [7:0] DELAY_CODE  = DEFAULT_DELAY_CODE,
    parameter int         DELAY_TICKS = 20,
    parameter int         DEB_TICKS   = 16
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic                iSTART,
    input  logic                iIRQ_N,
    i2c_reg_init_seq_if.master  bus,
    output logic                oBUSY,
    output logic                oREADY,
    output logic                oERR,
    output logic [7:0]          oERR_CNT
);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(ENTRIES - 1);
    localparam logic [7:0]        RETRY_MAX = 8'(MAX_RETRY);
    localparam logic [15:0]       DEB_LAST  = 16'(DEB_TICKS - 1);
    localparam logic [15:0]       DLY_MULT  = 16'(DELAY_TICKS);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic              w_tick;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [7:0]        r_retry;
    logic [15:0]       r_dly;
    logic [15:0]       r_deb;
    logic [23:0]       r_i2c_data;
    logic              r_go;
    logic              r_busy;
    logic              r_ready;
    logic              r_err;
    logic [7:0]        r_err_cnt;
    logic              r_irq_meta;
    logic              r_irq_sync;

    logic              w_is_delay;
    logic [15:0]       w_dly_load;
    logic              w_dly_done;
    logic              w_end_seen;
    logic              w_can_retry;
    logic              w_deb_hit;
    logic              w_restart;
    logic              w_go_set;
    logic              w_go_clr;
    logic              w_skip;
    logic              w_busy_nxt;
    logic              w_ready_nxt;

    i2c_tick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .I2C_FREQ (I2C_FREQ)
    ) u_tick_gen (
        .i_clk  (iCLK),
        .i_rst  (iRST),
        .o_tick (w_tick)
    );

    assign w_is_delay  = (bus.iROM_DATA[15:8] == DELAY_CODE);
    assign w_dly_load  = 16'(bus.iROM_DATA[7:0]) * DLY_MULT;
    // A zero count leaves at once; otherwise leave on the tick that would reach zero.
    assign w_dly_done  = (r_dly == 16'd0) || (w_tick && (r_dly == 16'd1));
    assign w_end_seen  = w_tick && bus.iI2C_END;
    assign w_can_retry = r_retry < RETRY_MAX;
    assign w_deb_hit   = w_tick && !r_irq_sync && (r_deb == DEB_LAST);
    // iSTART and a debounce hit in the same cycle collapse into one restart.
    assign w_restart   = (r_state == DONE) && (iSTART || w_deb_hit);

    // State register.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST)
            r_state <= FETCH;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FETCH: w_state_nxt = LOAD;
            LOAD:  w_state_nxt = w_is_delay ? DELAY : ISSUE;
            DELAY: if (w_dly_done) w_state_nxt = NEXT;
            ISSUE: if (w_tick) w_state_nxt = WAIT;
            WAIT: begin
                if (w_end_seen)
                    w_state_nxt = (bus.iI2C_ACK && w_can_retry) ? ISSUE : NEXT;
            end
            NEXT:  w_state_nxt = (r_idx == LAST_IDX) ? DONE : FETCH;
            DONE:  if (w_restart) w_state_nxt = FETCH;
            default: w_state_nxt = FETCH;
        endcase
    end

    // Output decode: strobes for the datapath and next values of the status flags.
    always_comb begin
        w_go_set    = (r_state == ISSUE) && w_tick;
        w_go_clr    = (r_state == WAIT) && w_end_seen;
        w_skip      = w_go_clr && bus.iI2C_ACK && !w_can_retry;
        w_busy_nxt  = (w_state_nxt != DONE);
        w_ready_nxt = (w_state_nxt == DONE);
    end

    // Table walk, transfer request and retry bookkeeping.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_idx      <= '0;
            r_rom_addr <= '0;
            r_retry    <= '0;
            r_dly      <= '0;
            r_i2c_data <= '0;
            r_go       <= 1'b0;
        end else begin
            if (r_state == FETCH)
                r_rom_addr <= r_idx;
            if (r_state == LOAD) begin
                if (w_is_delay)
                    r_dly <= w_dly_load;
                else
                    r_i2c_data <= {SLAVE_ADDR, bus.iROM_DATA};
            end
            if ((r_state == DELAY) && w_tick && (r_dly != 16'd0))
                r_dly <= r_dly - 16'd1;
            if (w_go_set)
                r_go <= 1'b1;
            else if (w_go_clr)
                r_go <= 1'b0;
            if (w_go_clr) begin
                if (bus.iI2C_ACK && w_can_retry)
                    r_retry <= r_retry + 8'd1;
                else
                    r_retry <= '0;
            end
            if ((r_state == NEXT) && (r_idx != LAST_IDX))
                r_idx <= r_idx + 1'b1;
            if (w_restart)
                r_idx <= '0;
        end
    end

    // Status flags and skipped-entry error tracking.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_busy    <= 1'b0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_ready <= w_ready_nxt;
            if (w_restart) begin
                r_err     <= 1'b0;
                r_err_cnt <= '0;
            end else if (w_skip) begin
                r_err <= 1'b1;
                if (r_err_cnt != 8'hFF)
                    r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    // Interrupt synchroniser and tick-based low-level debounce, active only in DONE.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_irq_meta <= 1'b1;
            r_irq_sync <= 1'b1;
            r_deb      <= '0;
        end else begin
            r_irq_meta <= iIRQ_N;
            r_irq_sync <= r_irq_meta;
            if ((r_state != DONE) || r_irq_sync)
                r_deb <= '0;
            else if (w_tick)
                r_deb <= r_deb + 16'd1;
        end
    end

    assign bus.oROM_ADDR = r_rom_addr;
    assign bus.oTICK     = w_tick;
    assign bus.oI2C_DATA = r_i2c_data;
    assign bus.oI2C_GO   = r_go;
    assign oBUSY         = r_busy;
    assign oREADY        = r_ready;
    assign oERR          = r_err;
    assign oERR_CNT      = r_err_cnt;

endmodule

// File: tb/tb_i2c_reg_init_seq.sv
// Directed bench for i2c_reg_init_seq with a behavioural ROM and I2C controller.
module tb_i2c_reg_init_seq;
    import i2c_cfg_pkg::*;

    localparam int DIV    = 4;
    localparam int ADDR_W = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       irq_n = 1'b1;
    logic       busy;
    logic       ready;
    logic       err;
    logic [7:0] err_cnt;

    i2c_reg_init_seq_if #(.ADDR_W(ADDR_W)) bus ();

    i2c_reg_init_seq #(
        .CLK_FREQ    (8),
        .I2C_FREQ    (1),
        .SLAVE_ADDR  (8'h72),
        .ENTRIES     (4),
        .ADDR_W      (ADDR_W),
        .MAX_RETRY   (3),
        .DELAY_CODE  (8'hFF),
        .DELAY_TICKS (20),
        .DEB_TICKS   (16)
    ) dut (
        .iCLK     (clk),
        .iRST     (rst),
        .iSTART   (start),
        .iIRQ_N   (irq_n),
        .bus      (bus),
        .oBUSY    (busy),
        .oREADY   (ready),
        .oERR     (err),
        .oERR_CNT (err_cnt)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [64];
    assign bus.iROM_DATA = rom[bus.oROM_ADDR];

    int n_chk = 0;
    int n_fail = 0;

    // Controller model state (written only by the model process).
    int          tick_idx;
    logic [23:0] go_data [$];
    int          go_cnt [4];
    int          go_step [4];
    int          end_step [4];
    int          streak [4];
    bit          active;
    int          lat;
    int          cur_ent;

    // Bench-owned NACK plan: consecutive NACKs to give per entry.
    int          nack_plan [4];
    int          snap [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, {31'd0, ready}, 32'd1);
    endtask

    task automatic take_snap();
        for (int i = 0; i < 4; i++) snap[i] = go_cnt[i];
    endtask

    function automatic int delta(input int i);
        return go_cnt[i] - snap[i];
    endfunction

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Behavioural I2C controller: END pulses for one tick, two ticks after GO is seen.
    initial begin
        bus.iI2C_END = 1'b0;
        bus.iI2C_ACK = 1'b0;
        active = 1'b0;
        lat = 0;
        cur_ent = 0;
        tick_idx = 0;
        for (int i = 0; i < 4; i++) begin
            go_cnt[i] = 0;
            go_step[i] = 0;
            end_step[i] = 0;
            streak[i] = 0;
        end
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.iI2C_END = 1'b0;
                bus.iI2C_ACK = 1'b0;
                active = 1'b0;
            end else if (bus.oTICK) begin
                tick_idx++;
                @(posedge clk);
                #1;
                if (!rst) begin
                    if (bus.iI2C_END) begin
                        bus.iI2C_END = 1'b0;
                        bus.iI2C_ACK = 1'b0;
                    end else if (active) begin
                        lat--;
                        if (lat == 0) begin
                            active = 1'b0;
                            bus.iI2C_END = 1'b1;
                            end_step[cur_ent] = tick_idx;
                            if (streak[cur_ent] < nack_plan[cur_ent]) begin
                                bus.iI2C_ACK = 1'b1;
                                streak[cur_ent]++;
                            end else begin
                                bus.iI2C_ACK = 1'b0;
                                streak[cur_ent] = 0;
                            end
                        end
                    end else if (bus.oI2C_GO) begin
                        active = 1'b1;
                        lat = 2;
                        cur_ent = (int'(bus.oI2C_DATA[15:12]) - 1) & 3;
                        go_data.push_back(bus.oI2C_DATA);
                        go_cnt[cur_ent]++;
                        go_step[cur_ent] = tick_idx;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int gap;
        int nt;
        logic [23:0] exp_tab [4];
        exp_tab[0] = 24'h7210A1;
        exp_tab[1] = 24'h7220B2;
        exp_tab[2] = 24'h7230C3;
        exp_tab[3] = 24'h7240D4;
        for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
        rom[0] = 16'h10A1;
        rom[1] = 16'h20B2;
        rom[2] = 16'h30C3;
        rom[3] = 16'h40D4;
        for (int i = 0; i < 4; i++) nack_plan[i] = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_err",   {31'd0, err}, 32'd0);
        check("rst_errcnt", {24'd0, err_cnt}, 32'd0);
        check("rst_go",    {31'd0, bus.oI2C_GO}, 32'd0);
        check("rst_tick",  {31'd0, bus.oTICK}, 32'd0);
        check("rst_addr",  {26'd0, bus.oROM_ADDR}, 32'd0);
        check("rst_data",  {8'd0, bus.oI2C_DATA}, 32'd0);

        // A: automatic run after reset, all entries ACK
        take_snap();
        base = go_data.size();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("A_busy", {31'd0, busy}, 32'd1);
        wait_ready("A");
        check("A_gos", 32'(go_data.size() - base), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("A_data%0d", i), {8'd0, go_data[base + i]}, {8'd0, exp_tab[i]});
        check("A_err", {31'd0, err}, 32'd0);
        check("A_busy_done", {31'd0, busy}, 32'd0);

        nt = 0;
        for (int i = 0; i < 10 * DIV; i++) begin
            @(negedge clk);
            if (bus.oTICK) nt++;
        end
        check("tick_rate", 32'(nt), 32'd10);

        // B: entry 2 NACKs twice then ACKs
        nack_plan[2] = 2;
        take_snap();
        base = go_data.size();
        do_start();
        check("B_ready_low", {31'd0, ready}, 32'd0);
        wait_ready("B");
        check("B_e2_gos", 32'(delta(2)), 32'd3);
        check("B_total", 32'(go_data.size() - base), 32'd6);
        check("B_err", {31'd0, err}, 32'd0);
        nack_plan[2] = 0;

        // C: entry 1 always NACKs -> 4 attempts then skipped
        nack_plan[1] = 99;
        take_snap();
        do_start();
        wait_ready("C");
        check("C_e1_gos", 32'(delta(1)), 32'd4);
        check("C_e2_gos", 32'(delta(2)), 32'd1);
        check("C_e3_gos", 32'(delta(3)), 32'd1);
        check("C_err", {31'd0, err}, 32'd1);
        check("C_errcnt", {24'd0, err_cnt}, 32'd1);
        nack_plan[1] = 0;

        // D: entry 1 is a 3-unit delay (60 ticks)
        rom[1] = 16'hFF03;
        take_snap();
        base = go_data.size();
        do_start();
        check("D_err_cleared", {31'd0, err}, 32'd0);
        check("D_errcnt_cleared", {24'd0, err_cnt}, 32'd0);
        wait_ready("D");
        gap = go_step[2] - end_step[0] - 1;
        check("D_gap_59_61", {31'd0, (gap >= 59 && gap <= 61)}, 32'd1);
        check("D_total", 32'(go_data.size() - base), 32'd3);
        check("D_e1_gos", 32'(delta(1)), 32'd0);
        rom[1] = 16'h20B2;

        // E: 15-tick interrupt glitch ignored, 16 ticks restarts
        base = go_data.size();
        @(negedge clk);
        irq_n = 1'b0;
        repeat (15 * DIV) @(negedge clk);
        irq_n = 1'b1;
        repeat (20 * DIV) @(negedge clk);
        check("E_glitch_ready", {31'd0, ready}, 32'd1);
        check("E_glitch_gos", 32'(go_data.size() - base), 32'd0);
        irq_n = 1'b0;
        repeat (16 * DIV) @(negedge clk);
        irq_n = 1'b1;
        repeat (8) @(negedge clk);
        check("E_irq_ready_low", {31'd0, ready}, 32'd0);
        check("E_irq_addr0", {26'd0, bus.oROM_ADDR}, 32'd0);
        wait_ready("E");
        check("E_irq_gos", 32'(go_data.size() - base), 32'd4);

        // F: start together with interrupt low -> one run only
        base = go_data.size();
        @(negedge clk);
        irq_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8 * DIV) @(negedge clk);
        irq_n = 1'b1;
        wait_ready("F");
        repeat (40 * DIV) @(negedge clk);
        check("F_single_run", 32'(go_data.size() - base), 32'd4);
        check("F_ready", {31'd0, ready}, 32'd1);

        // G: reset while waiting for END
        do_start();
        nt = 0;
        while (bus.oI2C_GO !== 1'b1 && nt < 500) begin
            @(negedge clk);
            nt++;
        end
        check("G_go_seen", {31'd0, bus.oI2C_GO}, 32'd1);
        rst = 1'b1;
        #1;
        check("G_go_async", {31'd0, bus.oI2C_GO}, 32'd0);
        check("G_busy", {31'd0, busy}, 32'd0);
        check("G_ready", {31'd0, ready}, 32'd0);
        check("G_addr", {26'd0, bus.oROM_ADDR}, 32'd0);
        repeat (3) @(negedge clk);
        base = go_data.size();
        rst = 1'b0;
        wait_ready("G");
        check("G_gos", 32'(go_data.size() - base), 32'd4);
        check("G_first", {8'd0, go_data[base]}, {8'd0, exp_tab[0]});
        check("G_err", {31'd0, err}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_reg_init_seq.md
Name: i2c_reg_init_seq

Overview:
Parametrised I2C register-initialisation sequencer, the generalised successor of the fixed HDMI-transmitter config block. It walks an external register table (ROM port), issues one 3-byte write per entry {slave, sub-addr, data} to the existing I2C byte controller via a GO/END/ACK handshake, and retries on NACK. Table-driven delay entries are supported. It re-runs the sequence on a debounced interrupt or a start pulse. It sits between a per-device LUT ROM and the shared I2C_Controller.

Parameters:
CLK_FREQ, 50000000, iCLK frequency in Hz
I2C_FREQ, 20000, controller work-clock rate in Hz; tick period = CLK_FREQ/(2*I2C_FREQ) iCLK cycles
SLAVE_ADDR, 8'h72, 8-bit write address prepended to every entry
ENTRIES, 31, number of table entries (1..2**ADDR_W)
ADDR_W, 6, table address width
MAX_RETRY, 3, NACK retries per entry before the entry is skipped
DELAY_CODE, 8'hFF, sub-address value marking a delay entry
DELAY_TICKS, 20, ticks per delay unit
DEB_TICKS, 16, consecutive low ticks required on iIRQ_N to trigger re-run

Ports:
iCLK  in  1  system clock
iRST  in  1  asynchronous, active-high reset
iSTART  in  1  one-cycle pulse; restart sequence (honoured only in DONE)
iIRQ_N  in  1  active-low device interrupt, asynchronous; 2-flop synchronised internally
oROM_ADDR  out  ADDR_W  table address
iROM_DATA  in  16  {sub_addr, data}; valid 1 iCLK after oROM_ADDR changes
oTICK  out  1  one-iCLK pulse per controller clock period (controller clock enable)
oI2C_DATA  out  24  {SLAVE_ADDR, sub_addr, data}
oI2C_GO  out  1  transfer request to controller
iI2C_END  in  1  controller transfer done
iI2C_ACK  in  1  1 = NACK seen (controller convention)
oBUSY  out  1  sequence in progress
oREADY  out  1  sequence complete
oERR  out  1  sticky: at least one entry skipped since last start
oERR_CNT  out  8  number of skipped entries, saturating at 255

Behaviour:
- Reset: all outputs 0; state FETCH, index 0, retry 0, tick counter 0. The sequence starts automatically when reset deasserts. Reset mid-transfer aborts immediately; GO drops asynchronously.
- Tick generator: counter 0..CLK_FREQ/(2*I2C_FREQ)-1; oTICK=1 on the wrap cycle. All handshake sampling and GO changes occur only on tick cycles.
- FETCH: oROM_ADDR<=index; next cycle -> LOAD.
- LOAD: if iROM_DATA[15:8]==DELAY_CODE, delay counter <= iROM_DATA[7:0]*DELAY_TICKS (16-bit) -> DELAY. Otherwise latch oI2C_DATA -> ISSUE.
- DELAY: decrement on tick; at 0 -> NEXT. A value of 0 passes through in 1 cycle.
- ISSUE: on tick, GO<=1 -> WAIT.
- WAIT: on tick with iI2C_END=1, GO<=0. If iI2C_ACK=0: retry<=0 -> NEXT. If iI2C_ACK=1 and retry<MAX_RETRY: retry+1 -> ISSUE (GO stays low for at least one tick). If iI2C_ACK=1 and retry==MAX_RETRY: oERR<=1, oERR_CNT+1 (saturating), retry<=0 -> NEXT.
- NEXT: if index==ENTRIES-1 -> DONE, else index+1 -> FETCH.
- DONE: oREADY=1, oBUSY=0. A debounce counter counts ticks with iIRQ_N(sync)=0 and clears on 1; reaching DEB_TICKS, or iSTART=1, causes: index<=0, oERR<=0, oERR_CNT<=0, oREADY<=0 -> FETCH.
- oBUSY=1 in every state except DONE.
- If iSTART and IRQ fire in the same cycle, a single restart occurs.
- iSTART and IRQ outside DONE are ignored; the debounce counter is held at 0.

Decomposition:
- Package i2c_cfg_pkg: state enum {FETCH, LOAD, DELAY, ISSUE, WAIT, NEXT, DONE}; tick-divisor constant function; default DELAY_CODE.
- Sub-module i2c_tick_gen: parametrised divider producing oTICK.
- Sequencer and debounce remain in the top module.

Test Plan:
- ENTRIES=4, all entries ACK -> 4 GO pulses with oI2C_DATA {72,xx,yy} in table order; oREADY=1, oERR=0 after the 4th END.
- Entry 2 NACKs twice then ACKs, MAX_RETRY=3 -> 3 GO pulses for entry 2; oERR=0; oREADY=1.
- Entry 1 always NACKs -> exactly 4 GO pulses for it; oERR=1, oERR_CNT=1; entries 2-3 are still written.
- Entry data 16'hFF03, DELAY_TICKS=20 -> 60 ticks (±1) between the preceding END and the next GO.
- In DONE: 15-tick iIRQ_N low glitch -> no restart; 16 ticks low -> oREADY=0, index 0, rerun; simultaneous iSTART -> single run.
- iRST asserted while in WAIT -> GO=0, outputs 0; after release the sequence restarts at index 0.
